// File: rtl/vs_timing_meas_pkg.sv
// Shared types and defaults for the frame-timing measurement stage.
package vs_timing_meas_pkg;

    localparam int DEF_W           = 12;
    localparam int DEF_TO_W        = 24;
    localparam int DEF_LOCK_FRAMES = 3;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    // Published geometry at the default counter width.
    typedef struct packed {
        logic [DEF_W-1:0] h;
        logic [DEF_W-1:0] v;
    } geom_t;

endpackage

// File: rtl/vs_timing_meas_line_counter.sv
// Per-frame line statistics: pixels per line, line count, line-length consistency.
// frame_* outputs already include a line that completes in the current cycle.
module vs_timing_meas_line_counter
    import vs_timing_meas_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         de,
    input  logic         frame_clr,
    output logic [W-1:0] frame_lines,
    output logic [W-1:0] frame_ref,
    output logic         frame_bad
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic         de_d;
    logic         skip;
    logic         bad;
    logic [W-1:0] pix_cnt;
    logic [W-1:0] line_cnt;
    logic [W-1:0] ref_len;

    logic line_done;
    logic first_line;
    logic mismatch;
    logic pix_sat;
    logic line_sat;

    // A line cut by a frame boundary is skipped until its de run ends.
    assign line_done  = de_d & ~de & ~skip;
    assign first_line = line_done & (line_cnt == '0);
    assign mismatch   = line_done & ~first_line & (pix_cnt != ref_len);
    assign pix_sat    = de & ~skip & (pix_cnt == CNT_MAX);
    assign line_sat   = line_done & (line_cnt == CNT_MAX);

    assign frame_lines = (line_done && !line_sat) ? line_cnt + 1'b1 : line_cnt;
    assign frame_ref   = first_line ? pix_cnt : ref_len;
    assign frame_bad   = bad | mismatch | pix_sat | line_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d     <= 1'b0;
            skip     <= 1'b0;
            bad      <= 1'b0;
            pix_cnt  <= '0;
            line_cnt <= '0;
            ref_len  <= '0;
        end else begin
            de_d <= de;
            if (frame_clr) begin
                skip     <= de;
                bad      <= 1'b0;
                pix_cnt  <= '0;
                line_cnt <= '0;
                ref_len  <= '0;
            end else begin
                if (skip && !de)
                    skip <= 1'b0;
                bad      <= frame_bad;
                line_cnt <= frame_lines;
                ref_len  <= frame_ref;
                if (line_done)
                    pix_cnt <= '0;
                else if (de && !skip && !pix_sat)
                    pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vs_timing_meas.sv
// Frame-timing measurement: publishes active pixels/lines per frame and declares
// lock once the geometry repeats for LOCK_FRAMES consistent frames.
module vs_timing_meas
    import vs_timing_meas_pkg::*;
#(
    parameter int W              = DEF_W,
    parameter int LOCK_FRAMES    = DEF_LOCK_FRAMES,
    parameter int VS_ACTIVE_HIGH = 1,
    parameter int TO_W           = DEF_TO_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vs_pos_edge,
    input  logic         vs_neg_edge,
    input  logic         de,
    output logic         frame_start,
    output logic [W-1:0] h_active,
    output logic [W-1:0] v_active,
    output logic         meas_valid,
    output logic         locked,
    output logic         lost,
    output logic [7:0]   frame_cnt,
    output state_t       dbg_state
);

    typedef struct packed {
        logic [W-1:0] h;
        logic [W-1:0] v;
    } geom_w_t;

    localparam logic [3:0]      LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [TO_W-1:0] WD_MAX = '1;

    logic         fe;
    logic [W-1:0] frame_lines;
    logic [W-1:0] frame_ref;
    logic         frame_bad;

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] wd;
    logic            wd_exp;
    logic [3:0]      stable_cnt;
    logic [3:0]      stable_nxt;
    logic            publish;
    logic            locked_d;
    geom_w_t         pub;

    assign fe        = (VS_ACTIVE_HIGH != 0) ? vs_pos_edge : vs_neg_edge;
    assign wd_exp    = (state == MEAS) && (wd == WD_MAX);
    assign h_active  = pub.h;
    assign v_active  = pub.v;
    assign dbg_state = state;

    vs_timing_meas_line_counter #(
        .W (W)
    ) u_line_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .de          (de),
        .frame_clr   (fe),
        .frame_lines (frame_lines),
        .frame_ref   (frame_ref),
        .frame_bad   (frame_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        stable_nxt = stable_cnt;
        publish    = 1'b0;
        case (state)
            IDLE: begin
                if (fe)
                    state_nxt = MEAS;
            end
            MEAS: begin
                if (fe) begin
                    if (!frame_bad && (frame_lines != '0)) begin
                        publish = 1'b1;
                        // Stability only grows when the pair repeats an earlier publish.
                        if ((frame_ref == pub.h) && (frame_lines == pub.v) && (stable_cnt != 4'd0))
                            stable_nxt = (stable_cnt >= LOCK_N) ? LOCK_N : stable_cnt + 4'd1;
                        else
                            stable_nxt = 4'd1;
                    end else begin
                        stable_nxt = 4'd0;
                    end
                end else if (wd_exp) begin
                    state_nxt  = IDLE;
                    stable_nxt = 4'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd          <= '0;
            stable_cnt  <= 4'd0;
            frame_start <= 1'b0;
            meas_valid  <= 1'b0;
            pub         <= '0;
            locked      <= 1'b0;
            locked_d    <= 1'b0;
            lost        <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            if (fe || (state != MEAS))
                wd <= '0;
            else
                wd <= wd + 1'b1;
            stable_cnt  <= stable_nxt;
            frame_start <= fe;
            meas_valid  <= publish;
            if (publish) begin
                pub.h <= frame_ref;
                pub.v <= frame_lines;
            end
            locked    <= (stable_nxt == LOCK_N);
            locked_d  <= locked;
            lost      <= locked_d & ~locked;
            frame_cnt <= frame_cnt + {7'd0, fe};
        end
    end

endmodule

// File: tb/tb_vs_timing_meas.sv
// Bench for vs_timing_meas: two instances (vsync active-high and active-low)
// checked every cycle against a frame-level model, plus hand-computed checkpoints.
module tb_vs_timing_meas;
    import vs_timing_meas_pkg::*;

    localparam int W      = 12;
    localparam int TO_W   = 6;
    localparam int LK     = 3;
    localparam int WD_LIM = 1 << TO_W;

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic vs_pos_edge = 1'b0;
    logic vs_neg_edge = 1'b0;
    logic de          = 1'b0;

    logic         fs [2];
    logic         mv [2];
    logic         lk [2];
    logic         ls [2];
    logic [W-1:0] ha [2];
    logic [W-1:0] va [2];
    logic [7:0]   fc [2];
    state_t       st [2];

    int n_checks = 0;
    int n_fail   = 0;
    int n_pos    = 0;
    int cnt_mv   [2];
    int cnt_lost [2];

    // Frame-level model state, one copy per instance.
    bit m_meas [2], m_skip [2], m_ded [2], m_mixed [2];
    int m_cur [2], m_nl [2], m_first [2], m_wd [2], m_stab [2];
    int e_fs [2], e_mv [2], e_h [2], e_v [2], e_lk [2], e_lkp [2], e_ls [2], e_fc [2];

    always #5 clk = ~clk;

    vs_timing_meas #(.W(W), .LOCK_FRAMES(LK), .VS_ACTIVE_HIGH(1), .TO_W(TO_W)) dut_p (
        .clk(clk), .rst_n(rst_n), .vs_pos_edge(vs_pos_edge), .vs_neg_edge(vs_neg_edge), .de(de),
        .frame_start(fs[0]), .h_active(ha[0]), .v_active(va[0]), .meas_valid(mv[0]),
        .locked(lk[0]), .lost(ls[0]), .frame_cnt(fc[0]), .dbg_state(st[0]));

    vs_timing_meas #(.W(W), .LOCK_FRAMES(LK), .VS_ACTIVE_HIGH(0), .TO_W(TO_W)) dut_n (
        .clk(clk), .rst_n(rst_n), .vs_pos_edge(vs_pos_edge), .vs_neg_edge(vs_neg_edge), .de(de),
        .frame_start(fs[1]), .h_active(ha[1]), .v_active(va[1]), .meas_valid(mv[1]),
        .locked(lk[1]), .lost(ls[1]), .frame_cnt(fc[1]), .dbg_state(st[1]));

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", name, inst, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_meas[i] = 0; m_skip[i] = 0; m_ded[i] = 0; m_mixed[i] = 0;
        m_cur[i] = 0; m_nl[i] = 0; m_first[i] = 0; m_wd[i] = 0; m_stab[i] = 0;
        e_fs[i] = 0; e_mv[i] = 0; e_h[i] = 0; e_v[i] = 0;
        e_lk[i] = 0; e_lkp[i] = 0; e_ls[i] = 0; e_fc[i] = 0;
    endtask

    // One clock of the model: collect finished line lengths, judge the frame at
    // each frame edge, and age the no-frame-edge timeout.
    task automatic model_step(input int i, input bit fe, input bit d);
        e_fs[i] = fe;
        e_mv[i] = 0;
        if (m_ded[i] && !d) begin
            if (m_skip[i])
                m_skip[i] = 0;
            else begin
                if (m_nl[i] == 0)
                    m_first[i] = m_cur[i];
                else if (m_cur[i] != m_first[i])
                    m_mixed[i] = 1;
                m_nl[i]++;
            end
            m_cur[i] = 0;
        end else if (d && !m_skip[i]) begin
            m_cur[i]++;
        end
        if (fe) begin
            if (m_meas[i]) begin
                if (m_nl[i] > 0 && !m_mixed[i]) begin
                    if (m_first[i] == e_h[i] && m_nl[i] == e_v[i] && m_stab[i] > 0)
                        m_stab[i] = (m_stab[i] + 1 > LK) ? LK : m_stab[i] + 1;
                    else
                        m_stab[i] = 1;
                    e_h[i]  = m_first[i];
                    e_v[i]  = m_nl[i];
                    e_mv[i] = 1;
                end else begin
                    m_stab[i] = 0;
                end
            end
            m_meas[i]  = 1;
            m_wd[i]    = 0;
            e_fc[i]    = (e_fc[i] + 1) % 256;
            m_nl[i]    = 0;
            m_mixed[i] = 0;
            m_cur[i]   = 0;
            m_skip[i]  = d;
        end else if (m_meas[i]) begin
            m_wd[i]++;
            if (m_wd[i] == WD_LIM) begin
                m_meas[i] = 0;
                m_stab[i] = 0;
            end
        end
        m_ded[i] = d;
        e_ls[i]  = (e_lkp[i] == 1 && e_lk[i] == 0) ? 1 : 0;
        e_lkp[i] = e_lk[i];
        e_lk[i]  = (m_stab[i] == LK) ? 1 : 0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, vs_pos_edge, de);
            model_step(1, vs_neg_edge, de);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("frame_start", i, int'(fs[i]), e_fs[i]);
            chk("meas_valid",  i, int'(mv[i]), e_mv[i]);
            chk("h_active",    i, int'(ha[i]), e_h[i]);
            chk("v_active",    i, int'(va[i]), e_v[i]);
            chk("locked",      i, int'(lk[i]), e_lk[i]);
            chk("lost",        i, int'(ls[i]), e_ls[i]);
            chk("frame_cnt",   i, int'(fc[i]), e_fc[i]);
            chk("state",       i, int'(st[i]), int'(m_meas[i]));
            cnt_mv[i]   += int'(mv[i]);
            cnt_lost[i] += int'(ls[i]);
        end
    end

    task automatic cyc(input bit p, input bit n, input bit d);
        @(negedge clk);
        vs_pos_edge = p;
        vs_neg_edge = n;
        de          = d;
        if (p)
            n_pos++;
    endtask

    task automatic run_line(input int len, input int gap);
        repeat (len) cyc(0, 0, 1);
        repeat (gap) cyc(0, 0, 0);
    endtask

    // Frame edge, 2 blank cycles, 4 lines of 8 pixels (line bad_line has 7),
    // 2 blank cycles after each line except the last, which gets tail.
    task automatic frame(input bit pol_neg, input int bad_line, input int tail);
        cyc(!pol_neg, pol_neg, 0);
        repeat (2) cyc(0, 0, 0);
        for (int l = 0; l < 4; l++)
            run_line((l == bad_line) ? 7 : 8, (l == 3) ? tail : 2);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, " frame_start"}, i, int'(fs[i]), 0);
            chk({tag, " meas_valid"},  i, int'(mv[i]), 0);
            chk({tag, " h_active"},    i, int'(ha[i]), 0);
            chk({tag, " v_active"},    i, int'(va[i]), 0);
            chk({tag, " locked"},      i, int'(lk[i]), 0);
            chk({tag, " lost"},        i, int'(ls[i]), 0);
            chk({tag, " frame_cnt"},   i, int'(fc[i]), 0);
            chk({tag, " state"},       i, int'(st[i]), 0);
        end
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Nominal: 5 frames of 4x8, publishes at frame edges 2..5.
        repeat (5) frame(0, -1, 2);
        chk("nominal mv count", 0, cnt_mv[0], 4);
        chk("nominal h", 0, int'(ha[0]), 8);
        chk("nominal v", 0, int'(va[0]), 4);
        chk("nominal locked", 0, int'(lk[0]), 1);
        chk("nominal frame_cnt", 0, int'(fc[0]), 5);

        // Line 2 short by one pixel: that frame is rejected and lock drops.
        frame(0, 1, 2);
        frame(0, -1, 2);
        chk("mismatch locked", 0, int'(lk[0]), 0);
        chk("mismatch lost", 0, cnt_lost[0], 1);
        repeat (3) frame(0, -1, 2);
        chk("relock mv count", 0, cnt_mv[0], 8);
        chk("relock locked", 0, int'(lk[0]), 1);

        // Last de falling edge coincides with the frame edge.
        frame(0, -1, 0);
        frame(0, -1, 2);
        chk("coincident v", 0, int'(va[0]), 4);
        chk("coincident mv count", 0, cnt_mv[0], 10);

        // Frame edge in the middle of a de run: the cut line is discarded.
        repeat (3) cyc(0, 0, 1);
        cyc(1, 0, 1);
        repeat (4) cyc(0, 0, 1);
        repeat (2) cyc(0, 0, 0);
        for (int l = 0; l < 4; l++)
            run_line(8, 2);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("split h", 0, int'(ha[0]), 8);
        chk("split v", 0, int'(va[0]), 4);
        chk("split mv count", 0, cnt_mv[0], 12);
        chk("split locked", 0, int'(lk[0]), 1);

        // Watchdog: no frame edge after the last one.
        k = 0;
        while (lk[0] && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("watchdog latency", 0, k, 64);
        repeat (2) cyc(0, 0, 0);
        chk("watchdog lost", 0, cnt_lost[0], 2);
        chk("watchdog state", 0, int'(st[0]), 0);
        repeat (4) frame(0, -1, 2);
        chk("post-watchdog mv count", 0, cnt_mv[0], 15);
        chk("post-watchdog locked", 0, int'(lk[0]), 1);

        // Active-low polarity: only vs_neg_edge pulses.
        repeat (5) frame(1, -1, 2);
        chk("neg frame_cnt", 1, int'(fc[1]), 5);
        chk("neg mv count", 1, cnt_mv[1], 4);
        chk("neg locked", 1, int'(lk[1]), 1);
        chk("neg h", 1, int'(ha[1]), 8);
        chk("pos frame_cnt held", 0, int'(fc[0]), n_pos % 256);
        chk("pos timed out", 0, int'(lk[0]), 0);
        chk("pos lost count", 0, cnt_lost[0], 3);

        // Reset mid-line while locked.
        repeat (3) cyc(0, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) cyc(0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) frame(0, -1, 2);
        chk("after reset frame_cnt", 0, int'(fc[0]), 5);
        chk("after reset mv count", 0, cnt_mv[0], 19);
        chk("after reset locked", 0, int'(lk[0]), 1);
        chk("after reset h", 0, int'(ha[0]), 8);
        chk("after reset v", 0, int'(va[0]), 4);
        chk("after reset lost count", 0, cnt_lost[0], 3);
        chk("neg lost count", 1, cnt_lost[1], 0);
        chk("neg idle after reset", 1, int'(st[1]), 0);

        repeat (3) cyc(0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
